// File: rtl/range_stats_pkg.sv
// Shared types for the range_stats measurement block.
// State encoding and error-cause codes, kept visible for debug.
package range_stats_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BOTH     = 3'd1;
    localparam logic [2:0] ERR_GO_RUN   = 3'd2;
    localparam logic [2:0] ERR_FIN_IDLE = 3'd3;
    localparam logic [2:0] ERR_EMPTY    = 3'd4;

endpackage

// File: rtl/range_cmp.sv
// Ordered compare of a sample against the current {max, min} pair.
// Yields the updated low and high bounds in one pass.
module range_cmp #(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0]      a,
    input  logic [1:0][WIDTH-1:0] b,
    output logic [WIDTH-1:0]      lo,
    output logic [WIDTH-1:0]      hi
);

    logic a_lt_lo;
    logic hi_lt_a;

    // b[0] is the running minimum, b[1] the running maximum
    generate
        if (SIGNED) begin : g_signed
            assign a_lt_lo = $signed(a) < $signed(b[0]);
            assign hi_lt_a = $signed(b[1]) < $signed(a);
        end else begin : g_unsigned
            assign a_lt_lo = a < b[0];
            assign hi_lt_a = b[1] < a;
        end
    endgenerate

    assign lo = a_lt_lo ? a : b[0];
    assign hi = hi_lt_a ? a : b[1];

endmodule

// File: rtl/range_stats.sv
// Windowed min/max/count tracker opened by go and closed by finish.
// Reports max - min on close; protocol misuse raises a sticky error.
module range_stats
    import range_stats_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             finish,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] range,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             error
);

    state_t           state;
    state_t           state_nx;
    logic             start;
    logic             close;
    logic [2:0]       err_cause;

    logic [WIDTH-1:0] acc_min;
    logic [WIDTH-1:0] acc_max;
    logic [CNT_W-1:0] acc_cnt;
    logic [WIDTH-1:0] nxt_min;
    logic [WIDTH-1:0] nxt_max;
    logic [CNT_W-1:0] nxt_cnt;
    logic [CNT_W-1:0] base_cnt;
    logic [WIDTH-1:0] cmp_lo;
    logic [WIDTH-1:0] cmp_hi;

    range_cmp #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_cmp (
        .a  (data_in),
        .b  ({acc_max, acc_min}),
        .lo (cmp_lo),
        .hi (cmp_hi)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (go && !finish) state_nx = RUN;
            RUN:  if (go || finish)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        start     = (state == IDLE) && go && !finish;
        close     = (state == RUN) && finish && !go;
        err_cause = ERR_NONE;
        if (go && finish) begin
            err_cause = ERR_BOTH;
        end else if ((state == RUN) && go) begin
            err_cause = ERR_GO_RUN;
        end else if ((state == IDLE) && finish) begin
            err_cause = ERR_FIN_IDLE;
        end else if (close && (nxt_cnt == '0)) begin
            err_cause = ERR_EMPTY;
        end
    end

    // A window opening from IDLE starts from an empty accumulator
    always_comb begin
        base_cnt = (state == RUN) ? acc_cnt : '0;
        nxt_min  = acc_min;
        nxt_max  = acc_max;
        nxt_cnt  = base_cnt;
        if (in_valid) begin
            if (base_cnt == '0) begin
                nxt_min = data_in;
                nxt_max = data_in;
            end else begin
                nxt_min = cmp_lo;
                nxt_max = cmp_hi;
            end
            nxt_cnt = (&base_cnt) ? base_cnt : base_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_min <= '0;
            acc_max <= '0;
            acc_cnt <= '0;
        end else if (start || (state == RUN)) begin
            acc_min <= nxt_min;
            acc_max <= nxt_max;
            acc_cnt <= nxt_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_out <= '0;
            max_out <= '0;
            range   <= '0;
            count   <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            done <= close;
            if (close) begin
                if (nxt_cnt == '0) begin
                    min_out <= '0;
                    max_out <= '0;
                    range   <= '0;
                    count   <= '0;
                end else begin
                    min_out <= nxt_min;
                    max_out <= nxt_max;
                    range   <= nxt_max - nxt_min;
                    count   <= nxt_cnt;
                end
            end
            if (start) begin
                error <= 1'b0;
            end else if (err_cause != ERR_NONE) begin
                error <= 1'b1;
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_range_stats.sv
// Directed table-driven bench for range_stats.
// Three instances: unsigned, signed, and a 3-bit saturating counter.
module tb_range_stats;

    logic        clk;
    logic        rst_n;
    logic        go;
    logic        finish;
    logic        in_valid;
    logic [15:0] data_in;

    logic [15:0] mn_u, mx_u, rg_u, ct_u;
    logic        b_u, d_u, e_u;
    logic [15:0] mn_s, mx_s, rg_s, ct_s;
    logic        b_s, d_s, e_s;
    logic [15:0] mn_c, mx_c, rg_c;
    logic [2:0]  ct_c;
    logic        b_c, d_c, e_c;

    int n_pass;
    int n_tot;

    range_stats #(.WIDTH(16), .SIGNED(1'b0), .CNT_W(16)) u_u (
        .clk(clk), .rst_n(rst_n), .go(go), .finish(finish),
        .in_valid(in_valid), .data_in(data_in),
        .min_out(mn_u), .max_out(mx_u), .range(rg_u), .count(ct_u),
        .busy(b_u), .done(d_u), .error(e_u)
    );

    range_stats #(.WIDTH(16), .SIGNED(1'b1), .CNT_W(16)) u_s (
        .clk(clk), .rst_n(rst_n), .go(go), .finish(finish),
        .in_valid(in_valid), .data_in(data_in),
        .min_out(mn_s), .max_out(mx_s), .range(rg_s), .count(ct_s),
        .busy(b_s), .done(d_s), .error(e_s)
    );

    range_stats #(.WIDTH(16), .SIGNED(1'b0), .CNT_W(3)) u_c (
        .clk(clk), .rst_n(rst_n), .go(go), .finish(finish),
        .in_valid(in_valid), .data_in(data_in),
        .min_out(mn_c), .max_out(mx_c), .range(rg_c), .count(ct_c),
        .busy(b_c), .done(d_c), .error(e_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          sel;
        bit          rst, go, fin, vld;
        logic [15:0] d;
        bit          b, dn, e;
        logic [15:0] mn, mx, rg, ct;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int sel, input bit rst, input bit g,
                       input bit f, input bit v, input logic [15:0] d,
                       input bit b, input bit dn, input bit e,
                       input logic [15:0] mn, input logic [15:0] mx,
                       input logic [15:0] rg, input logic [15:0] ct);
        vec_t x;
        x.sel = sel; x.rst = rst; x.go = g; x.fin = f; x.vld = v;
        x.d = d; x.b = b; x.dn = dn; x.e = e;
        x.mn = mn; x.mx = mx; x.rg = rg; x.ct = ct;
        tbl.push_back(x);
    endtask

    function automatic logic [66:0] act(input int sel);
        case (sel)
            1: return {b_s, d_s, e_s, mn_s, mx_s, rg_s, ct_s};
            2: return {b_c, d_c, e_c, mn_c, mx_c, rg_c, {13'd0, ct_c}};
            default: return {b_u, d_u, e_u, mn_u, mx_u, rg_u, ct_u};
        endcase
    endfunction

    task automatic check(input string nm, input logic [66:0] got,
                         input logic [66:0] exp);
        n_tot++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got b/d/e=%b min=%h max=%h rng=%h cnt=%h, want b/d/e=%b min=%h max=%h rng=%h cnt=%h",
                     nm, got[66:64], got[63:48], got[47:32], got[31:16],
                     got[15:0], exp[66:64], exp[63:48], exp[47:32],
                     exp[31:16], exp[15:0]);
        end
    endtask

    initial begin
        int seen;
        logic [15:0] cap_rg;
        logic [15:0] cap_ct;
        n_pass = 0;
        n_tot  = 0;
        rst_n = 1'b0; go = 1'b0; finish = 1'b0;
        in_valid = 1'b0; data_in = '0;

        // reset state of every instance
        add(0, 1, 0, 0, 0, 16'd0,   0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 16'd0,   0, 0, 0, 0, 0, 0, 0);
        add(2, 1, 0, 0, 0, 16'd0,   0, 0, 0, 0, 0, 0, 0);
        // unsigned basic window
        add(0, 0, 1, 0, 1, 16'd5,   1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 16'd300, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 16'd7,   1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 16'd42,  1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 16'd1000, 0, 1, 0, 5, 1000, 995, 5);
        add(0, 0, 0, 0, 0, 16'd0,   0, 0, 0, 5, 1000, 995, 5);
        // go+finish together in IDLE, then legal go clears error
        add(0, 0, 1, 1, 0, 16'd0,   0, 0, 1, 5, 1000, 995, 5);
        add(0, 0, 0, 0, 0, 16'd0,   0, 0, 1, 5, 1000, 995, 5);
        add(0, 0, 1, 0, 1, 16'd20,  1, 0, 0, 5, 1000, 995, 5);
        add(0, 0, 0, 0, 1, 16'd30,  1, 0, 0, 5, 1000, 995, 5);
        add(0, 0, 0, 0, 1, 16'd10,  1, 0, 0, 5, 1000, 995, 5);
        // go mid-window aborts
        add(0, 0, 1, 0, 1, 16'd0,   0, 0, 1, 5, 1000, 995, 5);
        add(0, 0, 0, 0, 0, 16'd0,   0, 0, 1, 5, 1000, 995, 5);
        // empty window
        add(0, 0, 1, 0, 0, 16'd0,   1, 0, 0, 5, 1000, 995, 5);
        add(0, 0, 0, 0, 0, 16'd0,   1, 0, 0, 5, 1000, 995, 5);
        add(0, 0, 0, 1, 0, 16'd0,   0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 16'd0,   0, 0, 1, 0, 0, 0, 0);
        // single-sample window, then finish in IDLE
        add(0, 0, 1, 0, 1, 16'd3,   1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 16'd0,   0, 1, 0, 3, 3, 0, 1);
        add(0, 0, 0, 1, 0, 16'd0,   0, 0, 1, 3, 3, 0, 1);
        // reset mid-window
        add(0, 0, 1, 0, 1, 16'd8,   1, 0, 0, 3, 3, 0, 1);
        add(0, 0, 0, 0, 1, 16'd9,   1, 0, 0, 3, 3, 0, 1);
        add(0, 1, 0, 0, 1, 16'd10,  0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 16'd0,   0, 0, 0, 0, 0, 0, 0);
        // signed full-scale range
        add(1, 0, 1, 0, 1, 16'hFFFC, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 16'h000A, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 16'h8000, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 16'h7FFF, 0, 1, 0, 16'h8000, 16'h7FFF, 16'hFFFF, 4);
        add(1, 0, 0, 0, 0, 16'd0,   0, 0, 0, 16'h8000, 16'h7FFF, 16'hFFFF, 4);
        // saturating 3-bit counter, then back-to-back window
        add(2, 1, 0, 0, 0, 16'd0,   0, 0, 0, 0, 0, 0, 0);
        add(2, 0, 1, 0, 1, 16'd50,  1, 0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 0, 1, 16'd99,  1, 0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 0, 1, 16'd20,  1, 0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 0, 1, 16'd1,   1, 0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 0, 1, 16'd60,  1, 0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 0, 1, 16'd70,  1, 0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 0, 1, 16'd2,   1, 0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 0, 1, 16'd3,   1, 0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 0, 1, 16'd4,   1, 0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 1, 1, 16'd5,   0, 1, 0, 1, 99, 98, 7);
        add(2, 0, 1, 0, 1, 16'd200, 1, 0, 0, 1, 99, 98, 7);
        add(2, 0, 0, 0, 1, 16'd150, 1, 0, 0, 1, 99, 98, 7);
        add(2, 0, 0, 1, 1, 16'd100, 0, 1, 0, 100, 200, 100, 3);
        add(2, 0, 0, 0, 0, 16'd0,   0, 0, 0, 100, 200, 100, 3);

        foreach (tbl[i]) begin
            rst_n    = !tbl[i].rst;
            go       = tbl[i].go;
            finish   = tbl[i].fin;
            in_valid = tbl[i].vld;
            data_in  = tbl[i].d;
            @(posedge clk);
            #1;
            check($sformatf("step%0d", i), act(tbl[i].sel),
                  {tbl[i].b, tbl[i].dn, tbl[i].e, tbl[i].mn,
                   tbl[i].mx, tbl[i].rg, tbl[i].ct});
        end

        // done must pulse exactly once within a bounded window
        rst_n = 1'b1; go = 1'b1; finish = 1'b0;
        in_valid = 1'b1; data_in = 16'd1;
        @(posedge clk); #1;
        go = 1'b0; finish = 1'b1; data_in = 16'd2;
        @(posedge clk); #1;
        finish = 1'b0; in_valid = 1'b0;
        seen = 0; cap_rg = '0; cap_ct = '0;
        for (int k = 0; k < 4; k++) begin
            if (d_u) begin
                seen++;
                cap_rg = rg_u;
                cap_ct = ct_u;
            end
            @(posedge clk); #1;
        end
        n_tot++;
        if (seen == 1) n_pass++;
        else $display("FAIL done_pulses: got %0d want 1", seen);
        n_tot++;
        if (cap_rg === 16'd1 && cap_ct === 16'd2) n_pass++;
        else $display("FAIL pulse_result: got rng=%0d cnt=%0d want rng=1 cnt=2",
                      cap_rg, cap_ct);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
